// File: rtl/branch_resolve_ctrl_if.sv
// Decode-to-execute branch issue bundle with valid/ready handshake.
// master = decode/issue side, slave = branch_resolve_ctrl.
interface branch_resolve_ctrl_if;
   logic        br_valid;
   logic        br_ready;
   logic [2:0]  branch_op;
   logic        is_jal;
   logic        is_jalr;
   logic [31:0] pc;
   logic [31:0] imm;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;

   modport master (
      output br_valid, branch_op, is_jal, is_jalr,
      output pc, imm, rs1_data, rs2_data,
      input  br_ready
   );

   modport slave (
      input  br_valid, branch_op, is_jal, is_jalr,
      input  pc, imm, rs1_data, rs2_data,
      output br_ready
   );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch resolve sequencer: drives branch_comp, redirects, flushes.
// Optional macro BRANCH_PREDICT_BTFN_EN: redirect only on BTFN mispredict.
module branch_resolve_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   branch_resolve_ctrl_if.slave dec,
   output logic [2:0]           cmp_op,
   output logic [31:0]          cmp_in1,
   output logic [31:0]          cmp_in2,
   input  logic                 cmp_result,
   output logic                 resolve_valid,
   output logic                 resolve_taken,
   output logic [31:0]          link_addr,
   output logic                 redirect_valid,
   output logic [31:0]          redirect_pc,
   output logic                 flush,
   output logic                 misalign_exc,
   output logic                 illegal_op,
   output logic [CNT_W-1:0]     br_count,
   output logic [CNT_W-1:0]     taken_count
`ifdef BRANCH_PREDICT_BTFN_EN
   ,
   output logic [CNT_W-1:0]     mispredict_count
`endif
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COMPARE  = 2'd1,
      REDIRECT = 2'd2,
      FLUSH    = 2'd3
   } state_t;

   localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic              jal_q, jal_d;
   logic              jalr_q, jalr_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       imm_q, imm_d;
   logic [31:0]       rs1_q, rs1_d;
   logic [31:0]       rs2_q, rs2_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              br_ready_q, br_ready_d;
   logic              resolve_valid_q, resolve_valid_d;
   logic              resolve_taken_q, resolve_taken_d;
   logic [31:0]       link_addr_q, link_addr_d;
   logic              redirect_valid_q, redirect_valid_d;
   logic [31:0]       redirect_pc_q, redirect_pc_d;
   logic              flush_q, flush_d;
   logic              misalign_q, misalign_d;
   logic              illegal_q, illegal_d;
   logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0]  tk_cnt_q, tk_cnt_d;
`ifdef BRANCH_PREDICT_BTFN_EN
   logic [CNT_W-1:0]  mp_cnt_q, mp_cnt_d;
   logic              pred;
   logic              mispred;
`endif

   logic              is_cond;
   logic              illegal;
   logic              taken;
   logic              misalign;
   logic              do_redir;
   logic [31:0]       target;
   logic [31:0]       pc4;
   logic [31:0]       redir_tgt;

   // Resolution math works only on latched operands, so it is valid in COMPARE.
   always_comb begin
      is_cond  = !jal_q && !jalr_q;
      illegal  = is_cond && (op_q[2:1] == 2'b01);
      taken    = jal_q || jalr_q || (is_cond && !illegal && cmp_result);
      target   = jalr_q ? ((rs1_q + imm_q) & ~32'd1) : (pc_q + imm_q);
      pc4      = pc_q + 32'd4;
      misalign = taken && target[1];
`ifdef BRANCH_PREDICT_BTFN_EN
      pred      = jal_q || (is_cond && imm_q[31]);
      mispred   = !illegal && !jalr_q && (taken != pred);
      do_redir  = jalr_q ? !misalign : (mispred && !misalign);
      redir_tgt = taken ? target : pc4;
`else
      do_redir  = taken && !misalign;
      redir_tgt = target;
`endif
   end

   always_comb begin
      state_d          = state_q;
      op_d             = op_q;
      jal_d            = jal_q;
      jalr_d           = jalr_q;
      pc_d             = pc_q;
      imm_d            = imm_q;
      rs1_d            = rs1_q;
      rs2_d            = rs2_q;
      cnt_d            = cnt_q;
      br_ready_d       = br_ready_q;
      resolve_valid_d  = 1'b0;
      resolve_taken_d  = resolve_taken_q;
      link_addr_d      = link_addr_q;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      flush_d          = flush_q;
      misalign_d       = 1'b0;
      illegal_d        = 1'b0;
      br_cnt_d         = br_cnt_q;
      tk_cnt_d         = tk_cnt_q;
`ifdef BRANCH_PREDICT_BTFN_EN
      mp_cnt_d         = mp_cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (dec.br_valid) begin
               op_d        = dec.branch_op;
               jal_d       = dec.is_jal;
               jalr_d      = dec.is_jalr;
               pc_d        = dec.pc;
               imm_d       = dec.imm;
               rs1_d       = dec.rs1_data;
               rs2_d       = dec.rs2_data;
               link_addr_d = dec.pc + 32'd4;
               br_ready_d  = 1'b0;
               state_d     = COMPARE;
            end
         end
         COMPARE: begin
            resolve_valid_d = 1'b1;
            resolve_taken_d = taken;
            misalign_d      = misalign;
            illegal_d       = illegal;
            redirect_pc_d   = redir_tgt;
            br_cnt_d        = sat_inc(br_cnt_q);
            if (taken) tk_cnt_d = sat_inc(tk_cnt_q);
`ifdef BRANCH_PREDICT_BTFN_EN
            if (mispred) mp_cnt_d = sat_inc(mp_cnt_q);
`endif
            if (do_redir) begin
               redirect_valid_d = 1'b1;
               flush_d          = 1'b1;
               state_d          = REDIRECT;
            end else begin
               br_ready_d = 1'b1;
               state_d    = IDLE;
            end
         end
         REDIRECT: begin
            flush_d = 1'b1;
            cnt_d   = FLUSH_INIT;
            state_d = FLUSH;
         end
         FLUSH: begin
            if (cnt_q == 4'd0) begin
               flush_d    = 1'b0;
               br_ready_d = 1'b1;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         op_q             <= 3'd0;
         jal_q            <= 1'b0;
         jalr_q           <= 1'b0;
         pc_q             <= 32'd0;
         imm_q            <= 32'd0;
         rs1_q            <= 32'd0;
         rs2_q            <= 32'd0;
         cnt_q            <= 4'd0;
         br_ready_q       <= 1'b1;
         resolve_valid_q  <= 1'b0;
         resolve_taken_q  <= 1'b0;
         link_addr_q      <= 32'd0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= 32'd0;
         flush_q          <= 1'b0;
         misalign_q       <= 1'b0;
         illegal_q        <= 1'b0;
         br_cnt_q         <= '0;
         tk_cnt_q         <= '0;
`ifdef BRANCH_PREDICT_BTFN_EN
         mp_cnt_q         <= '0;
`endif
      end else begin
         state_q          <= state_d;
         op_q             <= op_d;
         jal_q            <= jal_d;
         jalr_q           <= jalr_d;
         pc_q             <= pc_d;
         imm_q            <= imm_d;
         rs1_q            <= rs1_d;
         rs2_q            <= rs2_d;
         cnt_q            <= cnt_d;
         br_ready_q       <= br_ready_d;
         resolve_valid_q  <= resolve_valid_d;
         resolve_taken_q  <= resolve_taken_d;
         link_addr_q      <= link_addr_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         flush_q          <= flush_d;
         misalign_q       <= misalign_d;
         illegal_q        <= illegal_d;
         br_cnt_q         <= br_cnt_d;
         tk_cnt_q         <= tk_cnt_d;
`ifdef BRANCH_PREDICT_BTFN_EN
         mp_cnt_q         <= mp_cnt_d;
`endif
      end
   end

   // Comparator operands come straight from the latch, so they only move on accept.
   assign cmp_op         = op_q;
   assign cmp_in1        = rs1_q;
   assign cmp_in2        = rs2_q;
   assign dec.br_ready   = br_ready_q;
   assign resolve_valid  = resolve_valid_q;
   assign resolve_taken  = resolve_taken_q;
   assign link_addr      = link_addr_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign flush          = flush_q;
   assign misalign_exc   = misalign_q;
   assign illegal_op     = illegal_q;
   assign br_count       = br_cnt_q;
   assign taken_count    = tk_cnt_q;
`ifdef BRANCH_PREDICT_BTFN_EN
   assign mispredict_count = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with a behavioural branch_comp.
// Expected values are hand-computed for FLUSH_CYCLES=2.
module tb_branch_resolve_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  cmp_op;
   logic [31:0] cmp_in1;
   logic [31:0] cmp_in2;
   logic        cmp_result;
   logic        resolve_valid;
   logic        resolve_taken;
   logic [31:0] link_addr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
   logic        misalign_exc;
   logic        illegal_op;
   logic [31:0] br_count;
   logic [31:0] taken_count;
`ifdef BRANCH_PREDICT_BTFN_EN
   logic [31:0] mispredict_count;
   localparam bit BTFN = 1'b1;
`else
   localparam bit BTFN = 1'b0;
`endif

   int errors = 0;
   int checks = 0;
   int busy, nflush, nrv, nrdv, nmis, nill;
   logic rtaken;

   branch_resolve_ctrl_if u_if ();

   branch_resolve_ctrl #(
      .FLUSH_CYCLES (2),
      .CNT_W        (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .dec            (u_if),
      .cmp_op         (cmp_op),
      .cmp_in1        (cmp_in1),
      .cmp_in2        (cmp_in2),
      .cmp_result     (cmp_result),
      .resolve_valid  (resolve_valid),
      .resolve_taken  (resolve_taken),
      .link_addr      (link_addr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .misalign_exc   (misalign_exc),
      .illegal_op     (illegal_op),
      .br_count       (br_count),
      .taken_count    (taken_count)
`ifdef BRANCH_PREDICT_BTFN_EN
      ,
      .mispredict_count (mispredict_count)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural branch_comp; unknown codes answer 1 so illegal masking is visible.
   always_comb begin
      case (cmp_op)
         3'b000:  cmp_result = (cmp_in1 == cmp_in2);
         3'b001:  cmp_result = (cmp_in1 != cmp_in2);
         3'b100:  cmp_result = ($signed(cmp_in1) < $signed(cmp_in2));
         3'b101:  cmp_result = ($signed(cmp_in1) >= $signed(cmp_in2));
         3'b110:  cmp_result = (cmp_in1 < cmp_in2);
         3'b111:  cmp_result = (cmp_in1 >= cmp_in2);
         default: cmp_result = 1'b1;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic jal,
                        input logic jalr, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] a,
                        input logic [31:0] b);
      u_if.branch_op = op;
      u_if.is_jal    = jal;
      u_if.is_jalr   = jalr;
      u_if.pc        = pc;
      u_if.imm       = imm;
      u_if.rs1_data  = a;
      u_if.rs2_data  = b;
      u_if.br_valid  = 1'b1;
   endtask

   task automatic issue(input logic [2:0] op, input logic jal,
                        input logic jalr, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] a,
                        input logic [31:0] b);
      drive(op, jal, jalr, pc, imm, a, b);
      @(posedge clk);
      @(negedge clk);
      u_if.br_valid = 1'b0;
   endtask

   // Starts at the COMPARE negedge, steps until br_ready, tallying pulses.
   task automatic run_out();
      busy = 0; nflush = 0; nrv = 0; nrdv = 0; nmis = 0; nill = 0;
      rtaken = 1'bx;
      for (int i = 0; i < 20; i++) begin
         if (u_if.br_ready) break;
         busy++;
         @(negedge clk);
         if (flush) nflush++;
         if (redirect_valid) nrdv++;
         if (misalign_exc) nmis++;
         if (illegal_op) nill++;
         if (resolve_valid) begin
            nrv++;
            rtaken = resolve_taken;
         end
      end
      chk("idle_reached", 32'(u_if.br_ready), 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      u_if.br_valid = 1'b0;
      u_if.branch_op = 3'd0;
      u_if.is_jal = 1'b0;
      u_if.is_jalr = 1'b0;
      u_if.pc = 32'd0;
      u_if.imm = 32'd0;
      u_if.rs1_data = 32'd0;
      u_if.rs2_data = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(u_if.br_ready), 32'd1);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_brcnt", br_count, 32'd0);
      chk("rst_tkcnt", taken_count, 32'd0);
      chk("rst_rv", 32'(resolve_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // BEQ taken forward
      issue(3'b000, 0, 0, 32'h100, 32'h20, 32'd5, 32'd5);
      chk("beq_cmp_op", 32'(cmp_op), 32'd0);
      chk("beq_cmp_in1", cmp_in1, 32'd5);
      chk("beq_ready_lo", 32'(u_if.br_ready), 32'd0);
      run_out();
      chk("beq_busy", busy, 32'd4);
      chk("beq_flush", nflush, 32'd3);
      chk("beq_rdv", nrdv, 32'd1);
      chk("beq_taken", 32'(rtaken), 32'd1);
      chk("beq_rpc", redirect_pc, 32'h120);
      chk("beq_link", link_addr, 32'h104);
      chk("beq_tkcnt", taken_count, 32'd1);
      chk("beq_brcnt", br_count, 32'd1);

      // BLT signed: -1 < 1 taken
      issue(3'b100, 0, 0, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1);
      run_out();
      chk("blt_taken", 32'(rtaken), 32'd1);
      chk("blt_rpc", redirect_pc, 32'h240);
      chk("blt_busy", busy, 32'd4);
      chk("blt_tkcnt", taken_count, 32'd2);

      // BLTU: 0xFFFFFFFF < 1 false
      issue(3'b110, 0, 0, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1);
      run_out();
      chk("bltu_taken", 32'(rtaken), 32'd0);
      chk("bltu_busy", busy, 32'd1);
      chk("bltu_rdv", nrdv, 32'd0);
      chk("bltu_flush", nflush, 32'd0);
      chk("bltu_brcnt", br_count, 32'd3);
      chk("bltu_tkcnt", taken_count, 32'd2);

      // JALR misaligned target 0x202
      issue(3'b000, 0, 1, 32'h300, 32'h0, 32'h203, 32'd0);
      run_out();
      chk("jalr_mis", nmis, 32'd1);
      chk("jalr_mis_rdv", nrdv, 32'd0);
      chk("jalr_mis_rpc", redirect_pc, 32'h202);
      chk("jalr_mis_busy", busy, 32'd1);
      chk("jalr_mis_tk", taken_count, 32'd3);

      // JALR aligned target 0x204
      issue(3'b000, 0, 1, 32'h400, 32'hFFFF_FFFF, 32'h205, 32'd0);
      run_out();
      chk("jalr_rpc", redirect_pc, 32'h204);
      chk("jalr_link", link_addr, 32'h404);
      chk("jalr_rdv", nrdv, 32'd1);
      chk("jalr_busy", busy, 32'd4);
      chk("jalr_mis0", nmis, 32'd0);

      // Illegal funct3 010
      issue(3'b010, 0, 0, 32'h500, 32'h10, 32'd0, 32'd0);
      run_out();
      chk("ill_pulse", nill, 32'd1);
      chk("ill_taken", 32'(rtaken), 32'd0);
      chk("ill_rdv", nrdv, 32'd0);
      chk("ill_busy", busy, 32'd1);
      chk("ill_brcnt", br_count, 32'd6);
      chk("ill_tkcnt", taken_count, 32'd4);

      // JAL, then BNE held on br_valid through the busy period
      drive(3'b000, 1, 0, 32'h600, 32'h100, 32'd0, 32'd0);
      @(posedge clk);
      @(negedge clk);
      drive(3'b001, 0, 0, 32'h800, 32'h10, 32'd1, 32'd2);
      run_out();
      chk("jal_busy", busy, BTFN ? 32'd1 : 32'd4);
      chk("jal_rdv", nrdv, BTFN ? 32'd0 : 32'd1);
      chk("jal_rpc", redirect_pc, 32'h700);
      chk("jal_brcnt", br_count, 32'd7);
      chk("jal_link", link_addr, 32'h604);
      @(negedge clk);
      u_if.br_valid = 1'b0;
      chk("held_cmp_op", 32'(cmp_op), 32'd1);
      chk("held_cmp_in2", cmp_in2, 32'd2);
      run_out();
      chk("bne_rpc", redirect_pc, 32'h810);
      chk("bne_brcnt", br_count, 32'd8);
      chk("bne_tkcnt", taken_count, 32'd6);

      // Reset during FLUSH
      issue(3'b000, 0, 0, 32'h900, 32'h8, 32'd7, 32'd7);
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_flush", 32'(flush), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_flush", 32'(flush), 32'd0);
      chk("rst_mid_ready", 32'(u_if.br_ready), 32'd1);
      chk("rst_mid_brcnt", br_count, 32'd0);
      chk("rst_mid_tkcnt", taken_count, 32'd0);
      chk("rst_mid_rdv", 32'(redirect_valid), 32'd0);

      // BNE not taken after reset
      issue(3'b001, 0, 0, 32'hA00, 32'h10, 32'd3, 32'd3);
      run_out();
      chk("bnent_busy", busy, 32'd1);
      chk("bnent_brcnt", br_count, 32'd1);
      chk("bnent_tkcnt", taken_count, 32'd0);
      chk("bnent_link", link_addr, 32'hA04);

`ifdef BRANCH_PREDICT_BTFN_EN
      // Backward BNE taken: predicted, no redirect
      issue(3'b001, 0, 0, 32'hB00, 32'hFFFF_FFF8, 32'd1, 32'd2);
      run_out();
      chk("btfn_hit_busy", busy, 32'd1);
      chk("btfn_hit_rdv", nrdv, 32'd0);
      chk("btfn_hit_mp", mispredict_count, 32'd0);
      // Same branch not taken: mispredict back to pc+4
      issue(3'b001, 0, 0, 32'hB00, 32'hFFFF_FFF8, 32'd2, 32'd2);
      run_out();
      chk("btfn_miss_rdv", nrdv, 32'd1);
      chk("btfn_miss_rpc", redirect_pc, 32'hB04);
      chk("btfn_miss_mp", mispredict_count, 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
